// File: rtl/minmax_stream_pkg.sv
// Shared definitions for the min/max frame tracker: FSM encoding and index width helper.
package minmax_stream_pkg;

  // ACC collects a frame, HOLD presents its result until the consumer takes it.
  typedef enum logic {
    StAcc  = 1'b0,
    StHold = 1'b1
  } state_e;

  // Index width for a frame of n samples, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    if ($clog2(n) < 1) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/minmax_cmp.sv
// Magnitude comparator: lt = (a < b), gt = (a > b), signed or unsigned by parameter.
module minmax_cmp #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter int          SIGNED    = 0
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  output logic                 lt,
  output logic                 gt
);

  if (SIGNED != 0) begin : g_signed
    // Two's-complement ordering of the full-width operands.
    always_comb begin
      lt = $signed(a) < $signed(b);
      gt = $signed(a) > $signed(b);
    end
  end else begin : g_unsigned
    // Plain unsigned ordering.
    always_comb begin
      lt = a < b;
      gt = a > b;
    end
  end

endmodule

// File: rtl/minmax_stream.sv
// Streaming frame min/max finder: collects FRAME_LEN samples, then holds the minimum,
// maximum and their first positions until the consumer accepts them.
module minmax_stream
  import minmax_stream_pkg::*;
#(
  parameter int unsigned  BIT_WIDTH = 16,
  parameter int unsigned  FRAME_LEN = 8,
  parameter int           SIGNED    = 0,
  localparam int unsigned IDX_W     = idx_w(FRAME_LEN)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [BIT_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [BIT_WIDTH-1:0] out_min,
  output logic [BIT_WIDTH-1:0] out_max,
  output logic [IDX_W-1:0]     out_min_idx,
  output logic [IDX_W-1:0]     out_max_idx,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(FRAME_LEN - 1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       cnt_q, cnt_d;
  logic [BIT_WIDTH-1:0]   min_q, min_d;
  logic [BIT_WIDTH-1:0]   max_q, max_d;
  logic [IDX_W-1:0]       min_idx_q, min_idx_d;
  logic [IDX_W-1:0]       max_idx_q, max_idx_d;

  logic accept;
  logic new_lt_min;
  logic new_gt_max;
  logic unused_min_gt;
  logic unused_max_lt;

  // Only the strict-less result of the min compare and strict-greater of the max compare matter.
  minmax_cmp #(
    .BIT_WIDTH (BIT_WIDTH),
    .SIGNED    (SIGNED)
  ) u_cmp_min (
    .a  (in_data),
    .b  (min_q),
    .lt (new_lt_min),
    .gt (unused_min_gt)
  );

  minmax_cmp #(
    .BIT_WIDTH (BIT_WIDTH),
    .SIGNED    (SIGNED)
  ) u_cmp_max (
    .a  (in_data),
    .b  (max_q),
    .lt (unused_max_lt),
    .gt (new_gt_max)
  );

  // Handshake outputs; results come straight from registers.
  always_comb begin
    in_ready    = (state_q == StAcc) && !reset;
    out_valid   = (state_q == StHold);
    out_min     = min_q;
    out_max     = max_q;
    out_min_idx = min_idx_q;
    out_max_idx = max_idx_q;
    accept      = in_valid && in_ready;
  end

  // Next-state: clr aborts everything; otherwise accumulate in ACC, wait for out_ready in HOLD.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    min_d     = min_q;
    max_d     = max_q;
    min_idx_d = min_idx_q;
    max_idx_d = max_idx_q;

    if (clr) begin
      state_d = StAcc;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StAcc: begin
          if (accept) begin
            if (cnt_q == '0) begin
              min_d     = in_data;
              max_d     = in_data;
              min_idx_d = '0;
              max_idx_d = '0;
            end else begin
              // Strict compares keep the earliest index on ties.
              if (new_lt_min) begin
                min_d     = in_data;
                min_idx_d = cnt_q;
              end
              if (new_gt_max) begin
                max_d     = in_data;
                max_idx_d = cnt_q;
              end
            end
            if (cnt_q == LastIdx) begin
              state_d = StHold;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            state_d = StAcc;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StAcc;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StAcc;
      cnt_q     <= '0;
      min_q     <= '0;
      max_q     <= '0;
      min_idx_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      min_q     <= min_d;
      max_q     <= max_d;
      min_idx_q <= min_idx_d;
      max_idx_q <= max_idx_d;
    end
  end

endmodule

// File: tb/tb_minmax_stream.sv
// Bench for minmax_stream: an unsigned and a signed instance driven with the same stimulus,
// checked against a frame-buffer reference model.
module tb_minmax_stream;

  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready_u, in_ready_s;
  logic        out_valid_u, out_valid_s;
  logic [15:0] out_min_u, out_max_u, out_min_s, out_max_s;
  logic [1:0]  min_idx_u, max_idx_u, min_idx_s, max_idx_s;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit          m_hold;
  bit          m_fresh;
  logic [15:0] m_frame [FL];
  int          m_cnt;
  logic [15:0] r_min_u, r_max_u, r_min_s, r_max_s;
  int          r_mni_u, r_mxi_u, r_mni_s, r_mxi_s;

  always #5 clk = ~clk;

  minmax_stream #(
    .BIT_WIDTH (16),
    .FRAME_LEN (FL),
    .SIGNED    (0)
  ) u_dut_u (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready_u),
    .out_min     (out_min_u),
    .out_max     (out_max_u),
    .out_min_idx (min_idx_u),
    .out_max_idx (max_idx_u),
    .out_valid   (out_valid_u),
    .out_ready   (out_ready)
  );

  minmax_stream #(
    .BIT_WIDTH (16),
    .FRAME_LEN (FL),
    .SIGNED    (1)
  ) u_dut_s (
    .clk         (clk),
    .reset       (reset),
    .clr         (clr),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready_s),
    .out_min     (out_min_s),
    .out_max     (out_max_s),
    .out_min_idx (min_idx_s),
    .out_max_idx (max_idx_s),
    .out_valid   (out_valid_s),
    .out_ready   (out_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int num(input logic [15:0] d, input bit sgn);
    if (sgn) return int'($signed(d));
    return int'({16'h0, d});
  endfunction

  // First occurrence of the smallest and largest value in the buffered frame.
  task automatic frame_minmax(input bit sgn, output logic [15:0] mn, output logic [15:0] mx,
                              output int mni, output int mxi);
    mn = m_frame[0]; mx = m_frame[0]; mni = 0; mxi = 0;
    for (int i = 1; i < FL; i++) begin
      if (num(m_frame[i], sgn) < num(mn, sgn)) begin mn = m_frame[i]; mni = i; end
      if (num(m_frame[i], sgn) > num(mx, sgn)) begin mx = m_frame[i]; mxi = i; end
    end
  endtask

  // One clock cycle: apply inputs, check settled outputs, advance model, pass the edge.
  task automatic drive(input logic v, input logic [15:0] d, input logic ordy,
                       input logic c, input logic r);
    in_valid = v; in_data = d; out_ready = ordy; clr = c; reset = r;
    #1;
    check_eq("in_ready_u", in_ready_u, !m_hold && !r);
    check_eq("in_ready_s", in_ready_s, !m_hold && !r);
    check_eq("out_valid_u", out_valid_u, m_hold);
    check_eq("out_valid_s", out_valid_s, m_hold);
    if (m_hold) begin
      check_eq("min_u", out_min_u, r_min_u);
      check_eq("max_u", out_max_u, r_max_u);
      check_eq("min_idx_u", min_idx_u, r_mni_u);
      check_eq("max_idx_u", max_idx_u, r_mxi_u);
      check_eq("min_s", out_min_s, r_min_s);
      check_eq("max_s", out_max_s, r_max_s);
      check_eq("min_idx_s", min_idx_s, r_mni_s);
      check_eq("max_idx_s", max_idx_s, r_mxi_s);
    end else if (m_fresh) begin
      check_eq("rst_out_u", {out_min_u, out_max_u}, 32'h0);
      check_eq("rst_idx_u", {min_idx_u, max_idx_u}, 32'h0);
      check_eq("rst_out_s", {out_min_s, out_max_s}, 32'h0);
      check_eq("rst_idx_s", {min_idx_s, max_idx_s}, 32'h0);
    end
    if (r) begin
      m_hold = 0; m_fresh = 1; m_cnt = 0;
    end else if (c) begin
      m_hold = 0; m_cnt = 0;
    end else if (m_hold) begin
      if (ordy) m_hold = 0;
    end else if (v) begin
      m_fresh = 0;
      m_frame[m_cnt] = d;
      m_cnt++;
      if (m_cnt == FL) begin
        frame_minmax(0, r_min_u, r_max_u, r_mni_u, r_mxi_u);
        frame_minmax(1, r_min_s, r_max_s, r_mni_s, r_mxi_s);
        m_hold = 1;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] e);
    drive(1, a, 1, 0, 0);
    drive(1, b, 1, 0, 0);
    drive(1, c, 1, 0, 0);
    drive(1, e, 1, 0, 0);
  endtask

  initial begin
    m_hold = 0; m_fresh = 1; m_cnt = 0;
    in_valid = 0; in_data = '0; out_ready = 0; clr = 0; reset = 1;
    @(posedge clk);
    #1;
    drive(1, 16'h1234, 1, 0, 1);
    drive(0, 16'h0, 0, 0, 0);

    // Back-to-back unsigned frame, then the result-taking cycle.
    send_frame(16'd5, 16'd2, 16'd9, 16'd2);
    drive(0, 16'h0, 1, 0, 0);

    // Same data seen with opposite signedness.
    send_frame(16'hFFFF, 16'd3, 16'h8000, 16'd0);
    drive(0, 16'h0, 1, 0, 0);

    // Stall in HOLD with a sample offered; it must not be consumed.
    send_frame(16'd10, 16'd20, 16'd30, 16'd40);
    for (int i = 0; i < 5; i++) drive(1, 16'd99, 0, 0, 0);
    drive(1, 16'd99, 1, 0, 0);
    send_frame(16'd1, 16'd2, 16'd3, 16'd4);
    drive(0, 16'h0, 1, 0, 0);

    // All-equal frame: earliest index wins.
    send_frame(16'd7, 16'd7, 16'd7, 16'd7);
    drive(0, 16'h0, 1, 0, 0);

    // Abort mid-frame, then a fresh frame, then reset while it is pending.
    drive(1, 16'd8, 1, 0, 0);
    drive(1, 16'd8, 1, 0, 0);
    drive(1, 16'd0, 1, 1, 0);
    send_frame(16'd1, 16'd4, 16'd0, 16'd3);
    drive(0, 16'h0, 0, 0, 1);
    drive(0, 16'h0, 0, 0, 0);

    // Randomized traffic with occasional clr and reset; small values force ties.
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] d;
      logic        v, o, c, r;
      d = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      v = ($urandom_range(0, 9) < 7);
      o = ($urandom_range(0, 1) == 1);
      c = ($urandom_range(0, 49) == 0);
      r = ($urandom_range(0, 99) == 0);
      drive(v, d, o, c, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/minmax_stream.md
MINMAX_STREAM -- requirements
Module: minmax_stream

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 8, samples per frame; legal range 2..256.
REQ-003 SHALL have parameter SIGNED, default 0; 0 = unsigned compare, 1 = two's-complement compare.
REQ-004 SHALL derive localparam IDX_W = max(1, clog2(FRAME_LEN)).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 clr  input  1  synchronous abort of the current frame and any pending result.
REQ-009 in_data  input  BIT_WIDTH  sample.
REQ-010 in_valid  input  1  sample present.
REQ-011 in_ready  output  1  block accepts sample this cycle.
REQ-012 out_min, out_max  output  BIT_WIDTH each  frame minimum and maximum.
REQ-013 out_min_idx, out_max_idx  output  IDX_W each  frame position (0-based) of min and max.
REQ-014 out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.

Function
REQ-015 SHALL accept a sample only on a cycle with in_valid && in_ready; a sample on any other cycle has no effect.
REQ-016 SHALL use two states: ACC (collecting frame) and HOLD (result pending); in_ready = (state==ACC) && !reset.
REQ-017 SHALL keep position counter cnt (0..FRAME_LEN-1), incremented per accepted sample in ACC.
REQ-018 On an accepted sample with cnt==0, SHALL load min=max=in_data and both indices=0.
REQ-019 On an accepted sample with cnt>0, SHALL replace min/min_idx only if in_data < min (strict), and max/max_idx only if in_data > max (strict); ties keep the earliest index.
REQ-020 Comparisons SHALL be signed when SIGNED=1, unsigned otherwise; no width extension or truncation of data.
REQ-021 On accepting the sample at cnt==FRAME_LEN-1, SHALL enter HOLD and assert out_valid on the next cycle with results including that sample (latency 1 cycle).
REQ-022 In HOLD, out_* SHALL stay stable and in_ready SHALL be 0 until out_valid && out_ready.
REQ-023 On out_valid && out_ready, SHALL deassert out_valid and return to ACC with cnt=0 on the next cycle; no same-cycle input bypass.
REQ-024 clr SHALL, in either state, force ACC, cnt=0, out_valid=0 next cycle; a sample presented with clr is discarded; clr has priority over input and output handshakes.
REQ-025 out_min, out_max and indices SHALL be registered outputs; values outside HOLD are don't-care for consumers but SHALL not be X after reset.

Reset
REQ-026 reset SHALL have priority over clr and all handshakes.
REQ-027 On reset: state=ACC, cnt=0, out_valid=0, out_min=out_max=0, out_min_idx=out_max_idx=0.
REQ-028 in_ready SHALL be 0 while reset is high and 1 the first cycle after release.
REQ-029 Reset mid-frame or in HOLD SHALL discard all partial/pending results.

Structure
REQ-030 A shared package/header SHALL hold the ACC/HOLD state encoding and the IDX_W width function.
REQ-031 Compare SHALL be a single sub-module minmax_cmp (BIT_WIDTH, SIGNED parameters; outputs lt, gt) instantiated twice.

Verification (BIT_WIDTH=16, FRAME_LEN=4)
REQ-032 Unsigned 5,2,9,2 back-to-back, out_ready=1 -> out_valid 1 cycle after 4th; min=2 idx=1, max=9 idx=2.
REQ-033 SIGNED=1, 0xFFFF,3,0x8000,0 -> min=0x8000 idx=2, max=3 idx=1; SIGNED=0 same data -> min=0 idx=3, max=0xFFFF idx=0.
REQ-034 out_ready held low 5 cycles in HOLD with in_valid=1 -> outputs stable, in_ready=0, no sample consumed; raise out_ready -> in_ready=1 next cycle, next frame starts at idx 0.
REQ-035 Frame 7,7,7,7 -> min=max=7, both idx=0.
REQ-036 clr after 2 samples, then 1,4,0,3 -> result min=0 idx=2, max=4 idx=1; reset asserted in HOLD -> out_valid=0, all outputs 0 next cycle.
